data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Initiator side of the data RAM bus: accepts one load/store request at a time from the MEM stage.
//  Generates ce/we/addr/sel/data toward data_ram and returns the aligned, sign/zero-extended load result.
//  Sits between mem stage and data_ram; drives stall_o to the pipeline control while busy.
// PARAMETERS
//  WAIT_CYCLES  1             extra RAM wait states per access (0..15)
//  BASE_ADDR    32'h0002_0000 byte address of RAM word 0
//  SIZE_BYTES   4096          RAM window size in bytes (power of 2)
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst_n       in   1   asynchronous reset, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   controller can accept (1 only in IDLE)
//  req_op      in   3   000 LB,001 LBU,010 LH,011 LHU,100 LW,101 SB,110 SH,111 SW
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   one-cycle pulse: response available
//  resp_rdata  out  32  extended load data (0 for stores and errors)
//  resp_err    out  1   address outside window (or misaligned, see CONFIGURATION)
//  stall_o     out  1   pipeline stall request
//  ram_ce      out  1   data_ram chip enable
//  ram_we      out  1   data_ram write enable
//  ram_addr    out  32  data_ram byte address, word aligned ([1:0]=00)
//  ram_sel     out  4   byte lane enables
//  ram_wdata   out  32  data_ram write data, lane-replicated
//  ram_rdata   in   32  data_ram read data (combinational)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; all other outputs 0; wait counter 0.
//  Accept on posedge with req_valid&req_ready; op/addr/wdata are latched, and inputs are ignored until IDLE again.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   - An out-of-window request goes IDLE -> RESP directly: resp_err=1, no ram_ce.
//  ACCESS lasts WAIT_CYCLES+1 cycles:
//   - ram_ce=1 throughout; ram_addr, ram_sel, ram_wdata are stable throughout.
//   - Stores: ram_we=1 only in the final ACCESS cycle (exactly one write).
//   - Loads: ram_we=0; ram_rdata is sampled at the end of the final ACCESS cycle.
//  RESP: exactly one cycle with resp_valid=1; then IDLE with req_ready=1.
//  Latency (accept edge -> resp_valid high) = WAIT_CYCLES+2 cycles; back-to-back throughput one access per WAIT_CYCLES+3.
//  stall_o = (state!=IDLE) | (req_valid & state==IDLE) (combinational); it drops in the IDLE cycle after RESP.
//  Window check: in = (req_addr - BASE_ADDR) < SIZE_BYTES, unsigned 32-bit; wrap below BASE_ADDR counts as out.
//  Lanes are big-endian; a = addr[1:0].
//   - Byte: sel = 4'b1000 >> a.
//   - Half: sel = a[1] ? 0011 : 1100.
//   - Word: sel = 1111.
//   - Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
//  Load extract:
//   - Byte = rdata[31-8a -: 8].
//   - Half = a[1] ? rdata[15:0] : rdata[31:16].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  Reset mid-operation: ram_ce/ram_we clear immediately (async), FSM to IDLE, and no response is produced for the aborted request.
//  resp_rdata/resp_err hold their last value after RESP; they are valid only while resp_valid=1.
// CONFIGURATION
//  MEM_MISALIGN_EXC_EN defined:
//   - Half with a[0]=1, or word with a!=0, skips ACCESS; RESP has resp_err=1 and resp_rdata=0.
//  MEM_MISALIGN_EXC_EN undefined:
//   - Offending low address bits are forced to zero (half a[0]=0, word a=00) and the access proceeds; never an error.
// TESTING
//  1. Reset, WAIT_CYCLES=1: SW addr 0x0002_0010 data 0xDEADBEEF -> ram_we high one cycle with sel=1111, addr 0x0002_0010; resp_valid at accept+3, resp_err=0.
//  2. Then LB 0x0002_0011 (ram_rdata=0xDEADBEEF) -> resp_rdata=0xFFFFFFAD; LBU -> 0x000000AD; LH 0x0002_0012 -> 0xFFFFBEEF.
//  3. SB 0x0002_0003 data 0x12345678 -> sel=0001, ram_wdata=0x78787878; SH 0x0002_0002 -> sel=0011, ram_wdata=0x56785678.
//  4. LW 0x0001_FFFC and LW 0x0002_1000 -> no ram_ce; resp_valid at accept+1 with resp_err=1, resp_rdata=0.
//  5. LW 0x0002_0001: with macro -> resp_err=1 and no ram_ce; without macro -> ram_addr=0x0002_0000 and resp_err=0.
//  6. Deassert rst_n during a SW's first ACCESS cycle -> ram_ce=ram_we=0 at once, no resp_valid; after release a new request is accepted normally.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding load/store initiator toward data_ram with lane steering and load extension.
// Optional MEM_MISALIGN_EXC_EN turns misaligned half/word accesses into error responses instead of forcing alignment.
module data_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int unsigned SIZE_BYTES  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_o,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d, cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        is_word, is_half, in_win, bad, last;
    logic [1:0]  a;
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] ld;

    assign is_word = (req_op == 3'b100) || (req_op == 3'b111);
    assign is_half = (req_op == 3'b010) || (req_op == 3'b011) || (req_op == 3'b110);
    assign in_win  = (req_addr - BASE_ADDR) < SIZE_BYTES;
`ifdef MEM_MISALIGN_EXC_EN
    assign bad = !in_win || (is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00);
    assign a   = req_addr[1:0];
`else
    assign bad = !in_win;
    assign a   = is_word ? 2'b00 : is_half ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
    assign last = cnt_q == 4'(WAIT_CYCLES);
    // Big-endian lanes: byte offset 0 lives in rdata[31:24]
    assign bv = ram_rdata[{~addr_q[1:0], 3'b000} +: 8];
    assign hv = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    assign ld = op_q == 3'b000 ? {{24{bv[7]}}, bv} :
                op_q == 3'b001 ? {24'h0, bv} :
                op_q == 3'b010 ? {{16{hv[15]}}, hv} :
                op_q == 3'b011 ? {16'h0, hv} :
                op_q == 3'b100 ? ram_rdata : 32'h0;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = req_op;
                addr_d  = {req_addr[31:2], a};
                sel_d   = is_word ? 4'b1111 : is_half ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> a;
                wdata_d = is_word ? req_wdata : is_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
                cnt_d   = 4'd0;
                if (bad) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
                state_d = bad ? RESP : ACCESS;
            end
            ACCESS: if (last) begin
                rdata_d = ld;
                err_d   = 1'b0;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            sel_q   <= 4'h0;
            cnt_q   <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign stall_o    = (state_q != IDLE) || req_valid;
    assign ram_ce     = state_q == ACCESS;
    assign ram_we     = ram_ce && op_q[2] && (op_q[1:0] != 2'b00) && last;
    assign ram_addr   = ram_ce ? {addr_q[31:2], 2'b00} : 32'h0;
    assign ram_sel    = ram_ce ? sel_q : 4'h0;
    assign ram_wdata  = ram_ce ? wdata_q : 32'h0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: vector table plus scoreboard for data_mem_ctrl, with reset-abort and back-to-back sequences.
module tb_data_mem_ctrl;
    localparam int W = 1;
    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, ram_rdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, stall_o, ram_ce, ram_we;
    logic [31:0] resp_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_sel;

    always #5 clk = ~clk;

    data_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'h0002_0000), .SIZE_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall_o(stall_o), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr, wdata, rdata;
        bit          acc;
        logic [31:0] eaddr;
        logic [3:0]  esel;
        logic [31:0] ewdata, erdata;
        bit          eerr;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t  vt[$];
    resp_t sbq[$];
    int    checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp();
        resp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
            e = sbq.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        end
    endtask

    task automatic run(input vec_t v);
        int ce = 0, we = 0, rc = 0, wecyc = -1;
        bit st = v.op >= SB;
        @(negedge clk);
        chk("req_ready", {31'h0, req_ready}, 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        ram_rdata = v.rdata;
        #1 chk("stall_on_req", {31'h0, stall_o}, 1);
        sbq.push_back('{v.erdata, v.eerr});
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = ~v.op;
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int n = 1; n <= W + 8 && rc == 0; n++) begin
            chk("stall_busy", {31'h0, stall_o}, 1);
            if (ram_ce) begin
                ce++;
                chk("ram_addr", ram_addr, v.eaddr);
                chk("ram_sel", {28'h0, ram_sel}, {28'h0, v.esel});
                chk("ram_wdata", ram_wdata, v.ewdata);
                if (ram_we) begin
                    we++;
                    wecyc = n;
                end
            end else begin
                chk("we_without_ce", {31'h0, ram_we}, 0);
            end
            if (resp_valid) begin
                rc = n;
                pop_cmp();
            end else begin
                @(negedge clk);
            end
        end
        chk("resp_latency", rc, v.acc ? W + 2 : 1);
        chk("ce_cycles", ce, v.acc ? W + 1 : 0);
        chk("we_cycles", we, (v.acc && st) ? 1 : 0);
        if (we > 0) chk("we_last_cycle", wecyc, W + 1);
        @(negedge clk);
        chk("resp_pulse", {31'h0, resp_valid}, 0);
        chk("ready_after", {31'h0, req_ready}, 1);
        chk("stall_drop", {31'h0, stall_o}, 0);
    endtask

    initial begin
        int r1 = -1, r2 = -1;
        vt.push_back('{SW,  32'h0002_0010, 32'hDEADBEEF, 32'h0,         1, 32'h0002_0010, 4'hF, 32'hDEADBEEF, 32'h0,         0});
        vt.push_back('{LB,  32'h0002_0011, 32'h0,        32'hDEADBEEF, 1, 32'h0002_0010, 4'h4, 32'h0,        32'hFFFFFFAD, 0});
        vt.push_back('{LBU, 32'h0002_0011, 32'h0,        32'hDEADBEEF, 1, 32'h0002_0010, 4'h4, 32'h0,        32'h000000AD, 0});
        vt.push_back('{LH,  32'h0002_0012, 32'h0,        32'hDEADBEEF, 1, 32'h0002_0010, 4'h3, 32'h0,        32'hFFFFBEEF, 0});
        vt.push_back('{LHU, 32'h0002_0010, 32'h0,        32'h80011234, 1, 32'h0002_0010, 4'hC, 32'h0,        32'h00008001, 0});
        vt.push_back('{LB,  32'h0002_0013, 32'h0,        32'h0000007F, 1, 32'h0002_0010, 4'h1, 32'h0,        32'h0000007F, 0});
        vt.push_back('{LB,  32'h0002_0000, 32'h0,        32'h80FFFFFF, 1, 32'h0002_0000, 4'h8, 32'h0,        32'hFFFFFF80, 0});
        vt.push_back('{LH,  32'h0002_0000, 32'h0,        32'h7FFF8000, 1, 32'h0002_0000, 4'hC, 32'h0,        32'h00007FFF, 0});
        vt.push_back('{LH,  32'h0002_0002, 32'h0,        32'hDEADBEEF, 1, 32'h0002_0000, 4'h3, 32'h0,        32'hFFFFBEEF, 0});
        vt.push_back('{SB,  32'h0002_0003, 32'h12345678, 32'h0,         1, 32'h0002_0000, 4'h1, 32'h78787878, 32'h0,         0});
        vt.push_back('{SH,  32'h0002_0002, 32'h12345678, 32'h0,         1, 32'h0002_0000, 4'h3, 32'h56785678, 32'h0,         0});
        vt.push_back('{SB,  32'h0002_0000, 32'h000000AB, 32'h0,         1, 32'h0002_0000, 4'h8, 32'hABABABAB, 32'h0,         0});
        vt.push_back('{LW,  32'h0001_FFFC, 32'h0,        32'h11111111, 0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
        vt.push_back('{LW,  32'h0002_1000, 32'h0,        32'h22222222, 0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
        vt.push_back('{LW,  32'h0002_0FFC, 32'h0,        32'hCAFEF00D, 1, 32'h0002_0FFC, 4'hF, 32'h0,        32'hCAFEF00D, 0});
        vt.push_back('{SW,  32'h0000_0000, 32'h00000055, 32'h0,         0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
        vt.push_back('{SB,  32'h0002_1003, 32'h00000066, 32'h0,         0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
`ifdef MEM_MISALIGN_EXC_EN
        vt.push_back('{LW,  32'h0002_0001, 32'h0,        32'h01020304, 0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
        vt.push_back('{LH,  32'h0002_0003, 32'h0,        32'hDEADBEEF, 0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
        vt.push_back('{SW,  32'h0002_0006, 32'hAABBCCDD, 32'h0,         0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
        vt.push_back('{LHU, 32'h0002_0001, 32'h0,        32'hABCD1234, 0, 32'h0,         4'h0, 32'h0,        32'h0,         1});
`else
        vt.push_back('{LW,  32'h0002_0001, 32'h0,        32'h01020304, 1, 32'h0002_0000, 4'hF, 32'h0,        32'h01020304, 0});
        vt.push_back('{LH,  32'h0002_0003, 32'h0,        32'hDEADBEEF, 1, 32'h0002_0000, 4'h3, 32'h0,        32'hFFFFBEEF, 0});
        vt.push_back('{SW,  32'h0002_0006, 32'hAABBCCDD, 32'h0,         1, 32'h0002_0004, 4'hF, 32'hAABBCCDD, 32'h0,         0});
        vt.push_back('{LHU, 32'h0002_0001, 32'h0,        32'hABCD1234, 1, 32'h0002_0000, 4'hC, 32'h0,        32'h0000ABCD, 0});
`endif

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 0);
        chk("rst_ce", {31'h0, ram_ce}, 0);
        chk("rst_we", {31'h0, ram_we}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_sel", {28'h0, ram_sel}, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_stall", {31'h0, stall_o}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", {31'h0, resp_err}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) run(vt[i]);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h0002_0040;
        req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_ce_before", {31'h0, ram_ce}, 1);
        chk("abort_we_before", {31'h0, ram_we}, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ce", {31'h0, ram_ce}, 0);
        chk("abort_we", {31'h0, ram_we}, 0);
        chk("abort_ready", {31'h0, req_ready}, 1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_resp_in_rst", {31'h0, resp_valid}, 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_resp", {31'h0, resp_valid}, 0);
            chk("abort_idle_ce", {31'h0, ram_ce}, 0);
        end
        run(vt[1]);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 32'h0002_0020;
        req_wdata = 32'h0;
        ram_rdata = 32'h13579BDF;
        for (int n = 0; n < 3 * (W + 3) + 4; n++) begin
            if (resp_valid) begin
                pop_cmp();
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
            end
            if (req_ready && req_valid) sbq.push_back('{32'h13579BDF, 1'b0});
            if (r2 >= 0) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_period", r2 - r1, W + 3);
        chk("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
